// File: rtl/mac_sequencer_if.sv
// Handshake and data bundle for the multi-cycle multiply-accumulate sequencer.
// The master side issues operations; the slave side (the sequencer) reports
// status and results.
interface mac_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] acc_in;
  logic [5:0]      shamt;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            ovf;

  modport master (
    output start, flush, op_a, op_b, acc_in, shamt,
    input  ready, busy, done, result, ovf
  );

  modport slave (
    input  start, flush, op_a, op_b, acc_in, shamt,
    output ready, busy, done, result, ovf
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequential shift-add multiplier followed by a shifted accumulate:
//   result = acc_in + low XLEN bits of ((op_a * op_b) >> shamt)
// One multiplier bit is consumed per cycle, LSB first.
// Optional build macro MAC_EARLY_TERM_EN: leave the multiply phase as soon
// as the remaining multiplier bits are all zero instead of always running
// the full XLEN steps.
module mac_sequencer #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_sequencer_if.slave bus
);
  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MULT, ACC, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   mcand;      // multiplicand, shifted left each step
  logic [PW-1:0]   product;
  logic [XLEN-1:0] mplier;     // multiplier, shifted right each step
  logic [XLEN-1:0] addend;
  logic [5:0]      shift;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] result;
  logic            ovf;

  logic            accept;
  logic            mult_last;
  logic [XLEN-1:0] shifted_low;
  logic [XLEN:0]   sum;

  assign accept = (state == IDLE) && bus.start && !bus.flush;

`ifdef MAC_EARLY_TERM_EN
  // Exit once no set multiplier bits remain beyond the one handled this cycle.
  assign mult_last = (count == LAST_STEP) || (mplier[XLEN-1:1] == '0);
`else
  assign mult_last = (count == LAST_STEP);
`endif

  // Logical right shift of the full product, then carry-producing add.
  assign shifted_low = XLEN'(product >> shift);
  assign sum         = {1'b0, addend} + {1'b0, shifted_low};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and status decode; flush overrides every transition.
  always_comb begin
    state_next = state;
    bus.ready  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_next = MULT;
      end
      MULT: begin
        bus.busy = 1'b1;
        if (mult_last) state_next = ACC;
      end
      ACC: begin
        bus.busy   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // Operand capture, shift-add datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      product <= '0;
      mplier  <= '0;
      addend  <= '0;
      shift   <= '0;
      count   <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand   <= PW'(bus.op_a);
            mplier  <= bus.op_b;
            addend  <= bus.acc_in;
            shift   <= bus.shamt;
            product <= '0;
            count   <= '0;
          end
        end
        MULT: begin
          if (!bus.flush) begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        ACC: begin
          // Result only updates on a completed operation; a flush keeps the old one.
          if (!bus.flush) begin
            result <= sum[XLEN-1:0];
            ovf    <= sum[XLEN];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result;
  assign bus.ovf    = ovf;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer. Expected results and
// latencies are hand computed; latencies follow MAC_EARLY_TERM_EN when the
// bench is built with it.
module tb_mac_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res;
  logic        last_ovf;

  always #5 clk = ~clk;

  mac_sequencer_if #(.XLEN(32)) bus ();

  mac_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MAC_EARLY_TERM_EN
  localparam int LAT_B5 = 5;
  localparam int LAT_B2 = 4;
  localparam int LAT_B4 = 5;
  localparam int LAT_B1 = 3;
  localparam int LAT_B0 = 3;
`else
  localparam int LAT_B5 = 34;
  localparam int LAT_B2 = 34;
  localparam int LAT_B4 = 34;
  localparam int LAT_B1 = 34;
  localparam int LAT_B0 = 34;
`endif
  localparam int LAT_FULL = 34;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation starting at a negedge, scramble the inputs after the
  // accepting edge, then wait (bounded) for done and check everything.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic [5:0] sh,
                        input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat);
    int  lat;
    bit  seen;
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    bus.op_a = a; bus.op_b = b; bus.acc_in = acc; bus.shamt = sh; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a = ~a; bus.op_b = ~b; bus.acc_in = ~acc; bus.shamt = ~sh;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (seen) begin
      check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
      check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
      $display("op %s: a=%08h b=%08h acc=%08h sh=%0d -> result=%08h ovf=%0b latency=%0d",
               tag, a, b, acc, sh, bus.result, bus.ovf, lat);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
      check({tag, "_result_hold"}, 64'(bus.result), 64'(exp_res));
    end
    last_res = exp_res;
    last_ovf = exp_ovf;
  endtask

  initial begin
    int done_cnt;
    int n;
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.acc_in = '0; bus.shamt = '0;

    // Reset state.
    #2;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function, accepted on the first edge after reset release.
    run_op("basic",   32'd3, 32'd5, 32'd7, 6'd0, 32'd22, 1'b0, LAT_B5);
    run_op("wrap_lo", 32'hFFFF_FFFF, 32'd2, 32'd1, 6'd0, 32'hFFFF_FFFF, 1'b0, LAT_B2);
    run_op("carry",   32'hFFFF_FFFF, 32'd2, 32'd2, 6'd0, 32'h0000_0000, 1'b1, LAT_B2);
    run_op("sh33",    32'h8000_0000, 32'd4, 32'd0, 6'd33, 32'd1, 1'b0, LAT_B4);
    run_op("sh63",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 6'd63, 32'h11, 1'b0, LAT_FULL);
    run_op("sh32",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 6'd32, 32'd1, 1'b1, LAT_FULL);
    run_op("b_one",   32'h1234_5678, 32'd1, 32'h1111_1111, 6'd0, 32'h2345_6789, 1'b0, LAT_B1);
    run_op("b_zero",  32'd5, 32'd0, 32'd9, 6'd0, 32'd9, 1'b0, LAT_B0);

    // Flush in cycle 10 of MULT: back to IDLE, no done, result kept.
    bus.op_a = 32'd1; bus.op_b = 32'hFFFF_FFFF; bus.acc_in = 32'd1; bus.shamt = '0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    check("flush_pre_busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ready", 64'(bus.ready), 64'd1);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_result", 64'(bus.result), 64'(last_res));
    check("flush_ovf", 64'(bus.ovf), 64'(last_ovf));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);
    $display("op flush: aborted in MULT cycle 10, result=%08h", bus.result);

    // Start and flush together: not accepted.
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("startflush_ready", 64'(bus.ready), 64'd1);
    check("startflush_busy", 64'(bus.busy), 64'd0);
    $display("op start+flush: ready=%0b busy=%0b", bus.ready, bus.busy);

    // Held start: ignored during DONE, re-accepted one cycle after done.
    bus.op_a = 32'd2; bus.op_b = 32'd3; bus.acc_in = 32'd4; bus.shamt = '0;
    bus.start = 1'b1;
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("held_done_seen", 64'(bus.done), 64'd1);
    check("held_result", 64'(bus.result), 64'd10);
    check("held_ready_in_done", 64'(bus.ready), 64'd0);
    @(negedge clk);
    check("held_ready_after", 64'(bus.ready), 64'd1);
    @(negedge clk);
    check("held_reaccept", 64'(bus.busy), 64'd1);
    $display("op held-start: result=%08h, reissued busy=%0b", bus.result, bus.busy);
    bus.start = 1'b0; bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("held_flush_ready", 64'(bus.ready), 64'd1);
    last_res = 32'd10;

    // Asynchronous reset in MULT cycle 20.
    bus.op_a = 32'd9; bus.op_b = 32'hFFFF_FFFF; bus.acc_in = 32'd1; bus.shamt = '0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_ovf", 64'(bus.ovf), 64'd0);
    $display("op reset: asserted in MULT cycle 20, result=%08h", bus.result);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'd100, 32'd1, 32'd23, 6'd0, 32'd123, 1'b0, LAT_B1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to issue a multiply-and-add; accepted only when ready=1.
REQ-005 flush  input  1  abort any operation in flight (pipeline flush).
REQ-006 op_a  input  XLEN  multiplicand, unsigned.
REQ-007 op_b  input  XLEN  multiplier, unsigned.
REQ-008 acc_in  input  XLEN  addend.
REQ-009 shamt  input  6  post-multiply right shift, taken from IMM[5:0] of the multiply-and-add opcode 000111.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 busy  output  1  high in MULT or ACC.
REQ-012 done  output  1  one-cycle pulse; result and ovf valid in that cycle.
REQ-013 result  output  XLEN  accumulated result; holds until the next done.
REQ-014 ovf  output  1  carry out of the accumulate add; holds with result.

Function
REQ-015 States: IDLE, MULT, ACC, DONE; encoding is free.
REQ-016 IDLE: start=1 and flush=0 latches op_a, op_b, acc_in and shamt, clears the 64-bit product register and the bit counter, and moves to MULT.
REQ-017 Operands are sampled only on the accepting edge; input changes afterwards have no effect.
REQ-018 MULT: one shift-add step per cycle, LSB first; 64-bit product; the counter increments each cycle.
REQ-019 MULT exits to ACC after 32 steps (counter wraps 31 to 0); counter overflow is not allowed to re-enter MULT.
REQ-020 ACC: computes sum = acc_in + low XLEN bits of (product >> shamt); the shift is logical.
REQ-021 shamt >= 32 shifts in upper product bits; shamt = 63 leaves bit 63 only; no saturation.
REQ-022 In ACC, sum wraps modulo 2^32; ovf = carry out of bit 31; result and ovf register on leaving ACC.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 A start during DONE is ignored (ready=0); the earliest new accept is the cycle after done.
REQ-025 Latency without early termination: done asserts 34 cycles after the accepting edge (32 MULT + 1 ACC + 1 DONE).
REQ-026 flush=1 in any state: return to IDLE on the next edge; done not asserted; result/ovf keep their previous values.
REQ-027 If start and flush are both high in the same cycle, flush wins and start is not accepted.
REQ-028 start held high continuously issues a new operation each time ready=1; there is no queueing.
REQ-029 Outputs are registered; no combinational path from inputs to done/result/ovf.

Reset
REQ-030 rst_n=0 immediately forces IDLE, with ready=1, busy=0, done=0, result=0, ovf=0, counter=0, product=0.
REQ-031 Reset asserted mid-operation discards the operation, with no done pulse.
REQ-032 On release, the first accept is possible on the first rising edge with rst_n=1.

Configuration
REQ-033 Macro MAC_EARLY_TERM_EN: when defined, MULT exits to ACC in the cycle after the remaining (shifted) multiplier bits are all zero, or after 32 steps, whichever is first.
REQ-034 With MAC_EARLY_TERM_EN defined and op_b=0, MULT lasts 1 cycle and latency is 3; result is identical to the fixed-latency build.
REQ-035 Without MAC_EARLY_TERM_EN, MULT always lasts exactly 32 cycles, independent of the data.

Verification
REQ-036 Scenario: op_a=3, op_b=5, acc_in=7, shamt=0 -> done at cycle 34, result=22, ovf=0.
REQ-037 Scenario: op_a=0xFFFFFFFF, op_b=2, acc_in=1, shamt=0 -> product low word 0xFFFFFFFE, result=0xFFFFFFFF, ovf=0; then acc_in=2 -> result=0, ovf=1.
REQ-038 Scenario: op_a=0x80000000, op_b=4, acc_in=0, shamt=33 -> product 0x2_0000_0000, result=1.
REQ-039 Scenario: flush at cycle 10 of MULT -> IDLE next edge, no done, result unchanged; start and flush in the same cycle -> not accepted.
REQ-040 Scenario: rst_n low at cycle 20 -> immediate IDLE with all outputs 0; a new start after release completes normally.
REQ-041 Scenario: with MAC_EARLY_TERM_EN, op_b=1 -> done at cycle 3, result = op_a + acc_in; without the macro, the same stimulus -> done at cycle 34.
